// File: rtl/game_turn_ctrl.sv
// -----------------------------------------------------------------------------
// game_turn_ctrl
//
// Turn sequencer for the two-player, ten-slot add-mod-10 game. This block is
// the only writer of the slot status register. It accepts committed moves,
// checks them, applies them, looks for a winner, hands the turn over, and
// forfeits a turn when too many time-base ticks pass without a move.
//
// Parameters
//   INIT_VAL    value loaded into every slot at game start (1..9)
//   TURN_TICKS  ticks allowed per turn before the turn is forfeited (2..255)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start_i        one-cycle pulse, starts a game from IDLE or GAME_OVER
//   tick_i         one-cycle time-base strobe
//   move_valid_i   one-cycle pulse, a move is presented on src/dst
//   src_idx_i      acting slot (must belong to the current player)
//   dst_idx_i      touched slot (must belong to the opponent)
//   status_o       slot values, slot s = status_o[4s+3:4s]
//                  slots 0..4 belong to player 0, slots 5..9 to player 1
//   player_o       player to move
//   busy_o         high in INIT, APPLY and CHECK
//   move_ack_o     one-cycle pulse when a move is written
//   move_nack_o    one-cycle pulse when a move is rejected
//   timeout_o      one-cycle pulse when a turn is forfeited
//   game_over_o    high while the game is over
//   winner_o       winning player, meaningful while game_over_o is high
//   turn_timer_o   ticks elapsed in the current turn
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module game_turn_ctrl #(
  parameter int INIT_VAL   = 1,
  parameter int TURN_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        tick_i,
  input  logic        move_valid_i,
  input  logic [3:0]  src_idx_i,
  input  logic [3:0]  dst_idx_i,
  output logic [39:0] status_o,
  output logic        player_o,
  output logic        busy_o,
  output logic        move_ack_o,
  output logic        move_nack_o,
  output logic        timeout_o,
  output logic        game_over_o,
  output logic        winner_o,
  output logic [7:0]  turn_timer_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_APPLY = 3'd3,
    ST_CHECK = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  localparam logic [3:0]  INIT_NIB   = 4'(INIT_VAL);
  localparam logic [7:0]  TICK_LIMIT = 8'(TURN_TICKS);
  localparam logic [39:0] INIT_FILL  = {10{INIT_NIB}};

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Reads one slot; an out-of-range index reads as 0.
  function automatic logic [3:0] get_slot(input logic [39:0] st, input logic [3:0] idx);
    logic [3:0] v;
    v = 4'd0;
    for (int s = 0; s < 10; s++) begin
      v = (idx == 4'(s)) ? st[4*s +: 4] : v;
    end
    return v;
  endfunction

  // Returns st with one slot replaced; an out-of-range index leaves st intact.
  function automatic logic [39:0] set_slot(input logic [39:0] st, input logic [3:0] idx,
                                           input logic [3:0] val);
    logic [39:0] r;
    r = st;
    for (int s = 0; s < 10; s++) begin
      r[4*s +: 4] = (idx == 4'(s)) ? val : r[4*s +: 4];
    end
    return r;
  endfunction

  // Mod-10 add of two digits: 5-bit sum, fold once when it reaches 10.
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end else begin
      sum = sum;
    end
    return sum[3:0];
  endfunction

  // True when idx is a slot of player p's row (this also bounds idx to 0..9).
  function automatic logic in_row(input logic [3:0] idx, input logic p);
    logic r;
    if (p == 1'b0) begin
      r = (idx <= 4'd4);
    end else begin
      r = (idx >= 4'd5) && (idx <= 4'd9);
    end
    return r;
  endfunction

  // True when all five slots of player p's row are zero.
  function automatic logic row_empty(input logic [39:0] st, input logic p);
    logic r;
    if (p == 1'b0) begin
      r = (st[19:0] == 20'd0);
    end else begin
      r = (st[39:20] == 20'd0);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [39:0] status_q, status_d;
  logic        player_q, player_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  src_q, src_d;
  logic [3:0]  dst_q, dst_d;
  logic        winner_q, winner_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        nack_q, nack_d;
  logic        timeout_q, timeout_d;
  logic        over_q, over_d;

  logic        move_ok_s;
  logic        tick_expire_s;
  logic [3:0]  src_val_s;
  logic [3:0]  dst_val_s;

  // Next-state and next-output logic for the turn sequencer.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    player_d  = player_q;
    timer_d   = timer_q;
    src_d     = src_q;
    dst_d     = dst_q;
    winner_d  = winner_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    timeout_d = 1'b0;

    // Row membership also rejects indices above 9.
    move_ok_s = in_row(src_idx_i, player_q) &&
                in_row(dst_idx_i, ~player_q) &&
                (get_slot(status_q, src_idx_i) != 4'd0) &&
                (get_slot(status_q, dst_idx_i) != 4'd0);

    // The tick that would bring the count to the limit forfeits the turn.
    tick_expire_s = ((timer_q + 8'd1) == TICK_LIMIT);

    src_val_s = get_slot(status_q, src_q);
    dst_val_s = get_slot(status_q, dst_q);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_INIT: begin
        status_d = INIT_FILL;
        player_d = 1'b0;
        timer_d  = 8'd0;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        if (move_valid_i && move_ok_s) begin
          // A valid move wins over a simultaneous tick.
          src_d   = src_idx_i;
          dst_d   = dst_idx_i;
          state_d = ST_APPLY;
        end else begin
          if (move_valid_i) begin
            nack_d = 1'b1;
          end else begin
            nack_d = 1'b0;
          end
          if (tick_i) begin
            if (tick_expire_s) begin
              timeout_d = 1'b1;
              player_d  = ~player_q;
              timer_d   = 8'd0;
            end else begin
              timer_d = timer_q + 8'd1;
            end
          end else begin
            timer_d = timer_q;
          end
        end
      end

      ST_APPLY: begin
        status_d = set_slot(status_q, src_q, add_mod10(src_val_s, dst_val_s));
        ack_d    = 1'b1;
        state_d  = ST_CHECK;
      end

      ST_CHECK: begin
        // Only the mover's source slot changed, so only the mover can win.
        if (row_empty(status_q, player_q)) begin
          winner_d = player_q;
          state_d  = ST_OVER;
        end else begin
          player_d = ~player_q;
          timer_d  = 8'd0;
          state_d  = ST_WAIT;
        end
      end

      ST_OVER: begin
        if (start_i) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_OVER;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Level outputs follow the state being entered so they line up with it.
    busy_d = (state_d == ST_INIT) || (state_d == ST_APPLY) || (state_d == ST_CHECK);
    over_d = (state_d == ST_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      status_q  <= 40'd0;
      player_q  <= 1'b0;
      timer_q   <= 8'd0;
      src_q     <= 4'd0;
      dst_q     <= 4'd0;
      winner_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      player_q  <= player_d;
      timer_q   <= timer_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      winner_q  <= winner_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      over_q    <= over_d;
    end
  end

  assign status_o     = status_q;
  assign player_o     = player_q;
  assign busy_o       = busy_q;
  assign move_ack_o   = ack_q;
  assign move_nack_o  = nack_q;
  assign timeout_o    = timeout_q;
  assign game_over_o  = over_q;
  assign winner_o     = winner_q;
  assign turn_timer_o = timer_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
module tb_game_turn_ctrl;

  localparam int TT  = 10;
  localparam int IVAL = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        tick;
  logic        mv;
  logic [3:0]  src;
  logic [3:0]  dst;
  logic [39:0] status;
  logic        player;
  logic        busy;
  logic        ack;
  logic        nack;
  logic        tmo;
  logic        over;
  logic        winner;
  logic [7:0]  timer;

  int n_checks = 0;
  int n_fails  = 0;

  game_turn_ctrl #(.INIT_VAL(IVAL), .TURN_TICKS(TT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .tick_i       (tick),
    .move_valid_i (mv),
    .src_idx_i    (src),
    .dst_idx_i    (dst),
    .status_o     (status),
    .player_o     (player),
    .busy_o       (busy),
    .move_ack_o   (ack),
    .move_nack_o  (nack),
    .timeout_o    (tmo),
    .game_over_o  (over),
    .winner_o     (winner),
    .turn_timer_o (timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [39:0] act, logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: game phase, ten integer slots, rules applied directly.
  // ---------------------------------------------------------------------------
  localparam int PH_IDLE = 0, PH_INIT = 1, PH_WAIT = 2, PH_APPLY = 3, PH_CHECK = 4, PH_OVER = 5;

  int m_phase;
  int m_slot [10];
  bit m_player;
  bit m_winner;
  int m_timer;
  int m_src;
  int m_dst;
  bit m_ack, m_nack, m_to;

  function automatic bit legal(int s, int d);
    if (s > 9 || d > 9) return 1'b0;
    if (m_player == 1'b0) begin
      if (!(s < 5 && d >= 5)) return 1'b0;
    end else begin
      if (!(s >= 5 && d < 5)) return 1'b0;
    end
    return (m_slot[s] != 0) && (m_slot[d] != 0);
  endfunction

  function automatic int row_sum(bit p);
    int t;
    t = 0;
    for (int i = 0; i < 5; i++) t += m_slot[(p ? 5 : 0) + i];
    return t;
  endfunction

  function automatic logic [39:0] m_status();
    logic [39:0] r;
    r = 40'd0;
    for (int i = 0; i < 10; i++) r[4*i +: 4] = 4'(m_slot[i]);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= PH_IDLE;
      for (int i = 0; i < 10; i++) m_slot[i] <= 0;
      m_player <= 1'b0;
      m_winner <= 1'b0;
      m_timer  <= 0;
      m_src    <= 0;
      m_dst    <= 0;
      m_ack    <= 1'b0;
      m_nack   <= 1'b0;
      m_to     <= 1'b0;
    end else begin
      m_ack  <= 1'b0;
      m_nack <= 1'b0;
      m_to   <= 1'b0;
      case (m_phase)
        PH_IDLE, PH_OVER: if (start) m_phase <= PH_INIT;
        PH_INIT: begin
          for (int i = 0; i < 10; i++) m_slot[i] <= IVAL;
          m_player <= 1'b0;
          m_timer  <= 0;
          m_phase  <= PH_WAIT;
        end
        PH_WAIT: begin
          if (mv && legal(int'(src), int'(dst))) begin
            m_src   <= int'(src);
            m_dst   <= int'(dst);
            m_phase <= PH_APPLY;
          end else begin
            if (mv) m_nack <= 1'b1;
            if (tick) begin
              if (m_timer + 1 >= TT) begin
                m_to     <= 1'b1;
                m_player <= !m_player;
                m_timer  <= 0;
              end else begin
                m_timer <= m_timer + 1;
              end
            end
          end
        end
        PH_APPLY: begin
          m_slot[m_src] <= (m_slot[m_src] + m_slot[m_dst]) % 10;
          m_ack         <= 1'b1;
          m_phase       <= PH_CHECK;
        end
        PH_CHECK: begin
          if (row_sum(m_player) == 0) begin
            m_winner <= m_player;
            m_phase  <= PH_OVER;
          end else begin
            m_player <= !m_player;
            m_timer  <= 0;
            m_phase  <= PH_WAIT;
          end
        end
        default: m_phase <= PH_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    chk("status",    status,       m_status());
    chk("player",    40'(player),  40'(m_player));
    chk("timer",     40'(timer),   40'(m_timer));
    chk("busy",      40'(busy),    40'(m_phase == PH_INIT || m_phase == PH_APPLY || m_phase == PH_CHECK));
    chk("move_ack",  40'(ack),     40'(m_ack));
    chk("move_nack", 40'(nack),    40'(m_nack));
    chk("timeout",   40'(tmo),     40'(m_to));
    chk("game_over", 40'(over),    40'(m_phase == PH_OVER));
    if (m_phase == PH_OVER) chk("winner", 40'(winner), 40'(m_winner));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; mv = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // Returns two cycles after the start pulse is sampled (game in WAIT).
  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
  endtask

  // Returns one cycle after the move is sampled.
  task automatic send_move(int s, int d);
    @(negedge clk); mv = 1'b1; src = 4'(s); dst = 4'(d);
    @(negedge clk); mv = 1'b0;
  endtask

  task automatic tick_n(int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  // Lets the current player's turn run out.
  task automatic forfeit();
    bit p0;
    int k;
    p0 = m_player;
    k = 0;
    while (m_player == p0 && k < 2 * TT) begin
      tick_n(1);
      k++;
    end
    if (m_player == p0) chk("forfeit_bound", 40'(m_player), 40'(!p0));
  endtask

  // Plays a move for whichever row owns src, forfeiting the other turn first.
  task automatic play(int s, int d);
    bit mover;
    mover = (s >= 5);
    if (m_player != mover) forfeit();
    send_move(s, d);
    cyc(2);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; tick = 1'b0; mv = 1'b0; src = 4'd0; dst = 4'd0;
    #2 rst_n = 1'b0;
    cyc(2);
    // Reset state
    chk("rst_status", status, 40'h0);
    chk("rst_flags", {32'd0, busy, ack, nack, tmo, over, winner, player, 1'b0}, 40'h0);
    chk("rst_timer", 40'(timer), 40'h0);
    rst_n = 1'b1;

    // Start: two cycles later all slots hold INIT_VAL
    do_start();
    chk("start_status", status, 40'h1111111111);
    chk("start_player", 40'(player), 40'h0);
    chk("start_busy", 40'(busy), 40'h0);

    // Valid move (0,7)
    send_move(0, 7);
    chk("mv_busy_k", 40'(busy), 40'h1);
    cyc(1);
    chk("mv_ack_k1", 40'(ack), 40'h1);
    chk("mv_status_k1", status, 40'h1111111112);
    cyc(1);
    chk("mv_player_k2", 40'(player), 40'h1);
    chk("mv_busy_k2", 40'(busy), 40'h0);

    // Rejections with player 0 to move
    forfeit();
    chk("rej_player0", 40'(player), 40'h0);
    send_move(6, 1);
    chk("rej_wrong_row_nack", 40'(nack), 40'h1);
    send_move(0, 3);
    chk("rej_same_row_nack", 40'(nack), 40'h1);
    send_move(12, 7);
    chk("rej_src12_nack", 40'(nack), 40'h1);
    send_move(0, 13);
    chk("rej_dst13_nack", 40'(nack), 40'h1);
    chk("rej_status", status, 40'h1111111112);
    chk("rej_player", 40'(player), 40'h0);

    // Wrap to exactly zero: slot 2 = 3, slot 5 = 7
    do_reset(); do_start();
    repeat (6) play(5, 0);
    repeat (2) play(2, 6);
    chk("wrap0_pre", status, 40'h1111711311);
    play(2, 5);
    chk("wrap0_post", status, 40'h1111711011);
    // dst slot holds 0
    send_move(6, 2);
    chk("rej_dst0_nack", 40'(nack), 40'h1);
    chk("rej_dst0_status", status, 40'h1111711011);
    chk("rej_dst0_player", 40'(player), 40'h1);

    // Wrap: slot 2 = 7, slot 5 = 8 gives 5
    do_reset(); do_start();
    repeat (7) play(5, 0);
    repeat (6) play(2, 6);
    chk("wrap_pre", status, 40'h1111811711);
    play(2, 5);
    chk("wrap_post", status, 40'h1111811511);

    // Win: row 0 = 0,0,0,0,9, slot 5 = 1, move (4,5)
    do_reset(); do_start();
    for (int s = 0; s < 4; s++) repeat (9) play(s, 6);
    repeat (8) play(4, 6);
    chk("win_pre", status, 40'h1111190000);
    if (m_player) forfeit();
    send_move(4, 5);
    cyc(1);
    chk("win_ack", 40'(ack), 40'h1);
    chk("win_status", status, 40'h1111100000);
    cyc(1);
    chk("win_over", 40'(over), 40'h1);
    chk("win_winner", 40'(winner), 40'h0);
    send_move(5, 0);
    chk("over_ignore_nack", 40'(nack), 40'h0);
    cyc(1);
    chk("over_ignore_ack", 40'(ack), 40'h0);
    chk("over_frozen", status, 40'h1111100000);
    do_start();
    chk("restart_status", status, 40'h1111111111);
    chk("restart_over", 40'(over), 40'h0);

    // Timeout
    do_reset(); do_start();
    tick_n(9);
    chk("to_timer9", 40'(timer), 40'd9);
    chk("to_none_yet", 40'(tmo), 40'h0);
    tick_n(1);
    chk("to_pulse", 40'(tmo), 40'h1);
    chk("to_player", 40'(player), 40'h1);
    chk("to_timer0", 40'(timer), 40'h0);
    chk("to_status", status, 40'h1111111111);
    cyc(1);
    chk("to_once", 40'(tmo), 40'h0);
    tick_n(9);
    @(negedge clk); tick = 1'b1; mv = 1'b1; src = 4'd0; dst = 4'd5;
    @(negedge clk); tick = 1'b0; mv = 1'b0;
    chk("to_nack_both", 40'(nack), 40'h1);
    chk("to_tmo_both", 40'(tmo), 40'h1);
    chk("to_both_player", 40'(player), 40'h0);
    // Valid move with a tick: the tick is dropped
    tick_n(5);
    @(negedge clk); tick = 1'b1; mv = 1'b1; src = 4'd0; dst = 4'd5;
    @(negedge clk); tick = 1'b0; mv = 1'b0;
    chk("mv_tick_timer", 40'(timer), 40'd5);
    chk("mv_tick_tmo", 40'(tmo), 40'h0);

    // Randomized play against the model
    do_reset(); do_start();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = (c == 2000) ? 1'b0 : 1'b1;
      start = ($urandom_range(0, 59) == 0);
      tick  = ($urandom_range(0, 3) == 0);
      mv    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 7) begin
        src = 4'((m_player ? 5 : 0) + $urandom_range(0, 4));
        dst = 4'((m_player ? 0 : 5) + $urandom_range(0, 4));
      end else begin
        src = 4'($urandom_range(0, 15));
        dst = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; tick = 1'b0; mv = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/game_turn_ctrl.md
# game_turn_ctrl

Turn sequencer for the two-player ten-slot add-mod-10 game. It owns the 40-bit slot status register and the current-player bit. It accepts committed moves from the cursor/selection front end, then validates and applies each move. After a move it checks for a winner, hands the turn over, and enforces a per-turn time limit driven by an external tick strobe. It sits between the button/selection logic and the display and score logic, and it is the single writer of `status`.

## Interface
- `INIT_VAL`, default 1: value loaded into every slot at game start; legal range 1–9.
- `TURN_TICKS`, default 10: number of `tick` strobes allowed per turn before it is forfeited; legal range 2–255.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; starts or restarts a game from IDLE or GAME_OVER.
- `tick`  in  1  single-cycle time-base strobe, e.g. 1 Hz.
- `move_valid`  in  1  single-cycle pulse; a move is presented on `src_idx`/`dst_idx`.
- `src_idx`  in  4  acting slot, 0–9; it must belong to the current player.
- `dst_idx`  in  4  touched slot, 0–9; it must belong to the opponent.
- `status`  out  40  slot values; slot s = `status[4s+3:4s]`; slots 0–4 belong to player 0, slots 5–9 to player 1.
- `player`  out  1  player to move.
- `busy`  out  1  high in INIT, APPLY and CHECK.
- `move_ack`  out  1  one-cycle pulse when a move is written.
- `move_nack`  out  1  one-cycle pulse when a move is rejected.
- `timeout`  out  1  one-cycle pulse when a turn is forfeited.
- `game_over`  out  1  high while in GAME_OVER.
- `winner`  out  1  winning player; meaningful only while `game_over` is high.
- `turn_timer`  out  8  ticks elapsed in the current turn.

## Operation
- States: IDLE, INIT, WAIT, APPLY, CHECK, GAME_OVER.
- **IDLE.** `start` moves to INIT. All other inputs are ignored.
- **INIT.** Every slot is loaded with `INIT_VAL`. `player` is set to 0 and `turn_timer` to 0. Next state is WAIT.
- **WAIT.** `move_valid` is sampled here. A move is valid only if all of the following hold:
  - `src_idx` ≤ 9 and `dst_idx` ≤ 9;
  - `src` is in the current player's row and `dst` is in the opponent's row;
  - `status[src]` ≠ 0 and `status[dst]` ≠ 0.
- A valid move latches `src`/`dst` and goes to APPLY.
- An invalid move pulses `move_nack` and stays in WAIT.
- **APPLY.** `status[src]` ← (`status[src]` + `status[dst]`) mod 10. This is computed with a 5-bit sum, and 10 is subtracted when the sum is ≥ 10. `status[dst]` is unchanged. `move_ack` pulses. Next state is CHECK.
- **CHECK.**
  - If all five slots of the mover's row are 0: `winner` ← `player`, go to GAME_OVER.
  - Otherwise: toggle `player`, set `turn_timer` to 0, go to WAIT.
- **Timer (WAIT only).** Each `tick` increments `turn_timer`.
  - On the tick that would reach `TURN_TICKS`, the turn is forfeited instead: `timeout` pulses, `player` toggles, `turn_timer` is set to 0, and the state stays WAIT.
  - `status` is unchanged by a forfeit.
- **GAME_OVER.** `status` and `winner` are frozen. `start` goes to INIT. All other inputs are ignored.
- **Ignored inputs.**
  - `move_valid` outside WAIT is ignored: no ack and no nack.
  - `start` in INIT, WAIT, APPLY or CHECK is ignored.
  - `tick` outside WAIT is dropped.
- **Simultaneous events in WAIT.**
  - `move_valid` with a valid move plus `tick`: the move wins and the tick is dropped.
  - An invalid move plus an expiring `tick`: `move_nack` and `timeout` pulse in the same cycle, and the player toggles.
  - An invalid move plus a non-expiring `tick`: `move_nack` pulses and `turn_timer` increments.

## Timing
- **Reset values** (asynchronous on `rst_n` low):
  - state IDLE;
  - `status` = 0, `player` = 0, `turn_timer` = 0;
  - `busy`, `move_ack`, `move_nack`, `timeout`, `game_over` and `winner` all 0.
- Reset mid-game returns to IDLE immediately and loses the game state.
- All outputs are registered.
- **Valid move** sampled at edge k:
  - edge k: enter APPLY; `busy` is high from k.
  - edge k+1: `status` updated, `move_ack` high for one cycle, enter CHECK.
  - edge k+2: `player` toggles or `game_over` rises, and `busy` falls.
  - A new move is accepted from edge k+3 at the earliest.
- **Invalid move** at edge k: `move_nack` high during the cycle after k.
- **Start** at edge k: enter INIT; edge k+1: `status` loaded and enter WAIT.
- **Timeout:** `timeout` and the `player` toggle both appear on the cycle after the expiring tick edge.

## Test plan
- **Reset, then start.** Reset, then `start`. Two cycles later `status` = 0x1111111111, `player` = 0, `busy` = 0.
- **Valid move.** Slot 0 = 1 and slot 7 = 1, player 0, move (0, 7).
  - `move_ack` is seen at k+1 and slot 0 = 2 at k+1.
  - At k+2, `player` = 1.
- **Wrap-around arithmetic.** Slot 2 = 7, slot 5 = 8, move (2, 5). Slot 2 becomes 5. Then slot 2 = 3, slot 5 = 7: slot 2 becomes 0.
- **Rejections.** Each of the following gives `move_nack` with no `status` change and no player change:
  - move (6, 1) while player 0 moves;
  - move (0, 3), same row;
  - a move whose `dst` slot is 0;
  - `src_idx` = 12.
- **Win.** Player 0 row = 0,0,0,0,9 and slot 5 = 1, move (4, 5). Slot 4 = 0, then `game_over` = 1 and `winner` = 0. A later `move_valid` is ignored. `start` reinitializes.
- **Timeout.** With `TURN_TICKS` = 10, send 10 ticks in WAIT. `timeout` pulses once, `player` toggles, `turn_timer` = 0. Then send an invalid move together with the 10th tick: `move_nack` and `timeout` pulse in the same cycle.
